// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with byte/half/word loads and stores, sign or zero
// extension, fault detection, registered read with valid strobe and a post-reset clear sweep.
module data_memory_ctrl #(
   parameter int ADDR_BITS  = 8,
   parameter bit INIT_CLEAR = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  size,
   input  logic        unsignedLoad,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic        ready,
   output logic [31:0] readData,
   output logic        readValid,
   output logic        fault
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] LAST_WORD = ADDR_BITS'(DEPTH - 1);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_CLEAR = 2'd1,
      ST_IDLE  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;

   logic                 read_valid_q, read_valid_d;
   logic                 fault_q, fault_d;
   logic [1:0]           rd_size_q, rd_size_d;
   logic [1:0]           rd_lane_q, rd_lane_d;
   logic                 rd_uns_q, rd_uns_d;

   logic                 ready_int;
   logic                 clearing;
   logic                 req_any;
   logic                 accept;
   logic                 bad_both;
   logic                 bad_size;
   logic                 bad_align;
   logic                 bad_range;
   logic                 bad_req;
   logic                 load_ok;
   logic                 store_ok;
   logic [1:0]           lane;
   logic [ADDR_BITS-1:0] word_idx;

   logic [3:0]           lane_we;
   logic [31:0]          lane_wdata;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [31:0]          rd_word;

   logic [7:0]           byte_sel;
   logic [15:0]          half_sel;
   logic [31:0]          read_data_ext;

   // ------------------------------------------------------------------
   // Request decode and fault classification
   // ------------------------------------------------------------------
   always_comb begin
      lane      = address[1:0];
      word_idx  = address[ADDR_BITS+1:2];
      ready_int = (state_q == ST_IDLE);
      req_any   = MemRead | MemWrite;
      accept    = ready_int & req_any;

      bad_both  = MemRead & MemWrite;
      bad_size  = (size == 2'b11);
      bad_align = ((size == SZ_HALF) && address[0]) ||
                  ((size == SZ_WORD) && (address[1:0] != 2'b00));
      bad_range = ((address >> (ADDR_BITS + 2)) != 32'd0);
      bad_req   = bad_both | bad_size | bad_align | bad_range;

      load_ok   = accept & ~bad_req & MemRead;
      store_ok  = accept & ~bad_req & MemWrite;
   end

   // The sweep only runs once rst_n is released; RESET itself clears word 0.
   always_comb begin
      clearing = rst_n && INIT_CLEAR &&
                 ((state_q == ST_RESET) || (state_q == ST_CLEAR));
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         ST_RESET: begin
            if (INIT_CLEAR) begin
               clr_cnt_d = clr_cnt_q + 1'b1;
               state_d   = (clr_cnt_q == LAST_WORD) ? ST_IDLE : ST_CLEAR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_WORD) begin
               state_d   = ST_IDLE;
               clr_cnt_d = '0;
            end
         end
         ST_IDLE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d   = ST_RESET;
            clr_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_RESET;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Write port: clear sweep has priority, otherwise per-lane store enables
   // ------------------------------------------------------------------
   always_comb begin
      lane_we    = 4'b0000;
      mem_addr   = word_idx;
      lane_wdata = writeData;
      if (clearing) begin
         lane_we    = 4'b1111;
         mem_addr   = clr_cnt_q;
         lane_wdata = 32'd0;
      end else if (store_ok) begin
         case (size)
            SZ_BYTE: begin
               lane_we    = 4'b0001 << lane;
               lane_wdata = {4{writeData[7:0]}};
            end
            SZ_HALF: begin
               lane_we    = 4'b0011 << lane;
               lane_wdata = {2{writeData[15:0]}};
            end
            default: begin
               lane_we    = 4'b1111;
               lane_wdata = writeData;
            end
         endcase
      end
   end

   // One byte-wide RAM per lane keeps partial writes as simple per-lane enables.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] rd_byte_q;

         always_ff @(posedge clk) begin
            if (lane_we[gi]) begin
               lane_mem[mem_addr] <= lane_wdata[gi*8 +: 8];
            end
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rd_byte_q <= 8'd0;
            end else if (load_ok) begin
               rd_byte_q <= lane_mem[word_idx];
            end
         end

         assign rd_word[gi*8 +: 8] = rd_byte_q;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Load attributes and strobes
   // ------------------------------------------------------------------
   always_comb begin
      rd_size_d    = rd_size_q;
      rd_lane_d    = rd_lane_q;
      rd_uns_d     = rd_uns_q;
      read_valid_d = load_ok;
      fault_d      = accept & bad_req;
      if (load_ok) begin
         rd_size_d = size;
         rd_lane_d = lane;
         rd_uns_d  = unsignedLoad;
      end
   end

   // Reset attributes select a plain word so readData reads as zero after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_size_q    <= SZ_WORD;
         rd_lane_q    <= 2'b00;
         rd_uns_q     <= 1'b0;
         read_valid_q <= 1'b0;
         fault_q      <= 1'b0;
      end else begin
         rd_size_q    <= rd_size_d;
         rd_lane_q    <= rd_lane_d;
         rd_uns_q     <= rd_uns_d;
         read_valid_q <= read_valid_d;
         fault_q      <= fault_d;
      end
   end

   // ------------------------------------------------------------------
   // Right-justify and extend the registered word
   // ------------------------------------------------------------------
   always_comb begin
      case (rd_lane_q)
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = rd_lane_q[1] ? rd_word[31:16] : rd_word[15:0];

      case (rd_size_q)
         SZ_BYTE: read_data_ext = {{24{~rd_uns_q & byte_sel[7]}}, byte_sel};
         SZ_HALF: read_data_ext = {{16{~rd_uns_q & half_sel[15]}}, half_sel};
         default: read_data_ext = rd_word;
      endcase
   end

   assign ready     = ready_int;
   assign readData  = read_data_ext;
   assign readValid = read_valid_q;
   assign fault     = fault_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized self-checking bench for data_memory_ctrl against a byte-array reference model.
module tb_data_memory_ctrl;

   localparam int AB     = 4;
   localparam int DEPTH  = 2 ** AB;
   localparam int NBYTES = DEPTH * 4;

   logic        clk;
   logic        rst_n;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  size;
   logic        unsignedLoad;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        ready;
   logic [31:0] readData;
   logic        readValid;
   logic        fault;

   int n_checks;
   int n_fail;

   logic [7:0]  mm [NBYTES];
   logic [31:0] exp_rd;

   data_memory_ctrl #(.ADDR_BITS(AB), .INIT_CLEAR(1'b1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .size         (size),
      .unsignedLoad (unsignedLoad),
      .address      (address),
      .writeData    (writeData),
      .ready        (ready),
      .readData     (readData),
      .readValid    (readValid),
      .fault        (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      size         = 2'b10;
      unsignedLoad = 1'b0;
      address      = 32'd0;
      writeData    = 32'd0;
   endtask

   function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
      int b;
      logic [31:0] v;
      b = int'(a) % NBYTES;
      if (sz == 2'b00) begin
         v = {24'd0, mm[b]};
         if (!uns && mm[b][7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         v = {16'd0, mm[b+1], mm[b]};
         if (!uns && mm[b+1][7]) v = v | 32'hFFFF_0000;
      end else begin
         v = {mm[b+3], mm[b+2], mm[b+1], mm[b]};
      end
      return v;
   endfunction

   // One request cycle: drive, clock, then compare strobes and data against the model.
   task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd);
      logic bad;
      logic acc;
      logic exp_v;
      logic exp_f;
      int   nb;
      MemRead      = rd;
      MemWrite     = wr;
      size         = sz;
      unsignedLoad = uns;
      address      = a;
      writeData    = wd;
      acc = rd | wr;
      bad = (rd && wr) || (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
            (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'(NBYTES));
      exp_v = acc && !bad && rd;
      exp_f = acc && bad;
      if (exp_v) exp_rd = model_load(sz, uns, a);
      if (acc && !bad && wr) begin
         nb = 1 << sz;
         for (int i = 0; i < nb; i++) mm[int'(a) + i] = wd[8*i +: 8];
      end
      @(posedge clk);
      #1;
      $display("txn rd=%0d wr=%0d sz=%0d u=%0d a=%08h wd=%08h -> v=%0d f=%0d rdata=%08h",
               rd, wr, sz, uns, a, wd, readValid, fault, readData);
      chk("ready", 32'(ready), 32'd1);
      chk("readValid", 32'(readValid), 32'(exp_v));
      chk("fault", 32'(fault), 32'(exp_f));
      chk("readData", readData, exp_rd);
      idle_inputs();
   endtask

   task automatic ld_expect(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] val);
      req(1'b1, 1'b0, sz, uns, a, 32'd0);
      chk(tag, readData, val);
   endtask

   // Release reset and walk the sweep; optionally pulse reset at clear count 7.
   task automatic sweep(input bit mid_reset);
      rst_n = 1'b1;
      if (mid_reset) begin
         for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            chk("ready_pre", 32'(ready), 32'd0);
         end
         rst_n = 1'b0;
         @(posedge clk);
         #1;
         chk("ready_rst", 32'(ready), 32'd0);
         rst_n = 1'b1;
      end
      for (int i = 1; i <= DEPTH; i++) begin
         if (i < DEPTH) begin
            if (i >= 10) begin
               MemWrite  = 1'b1;
               size      = 2'b10;
               address   = 32'h0;
               writeData = 32'hCAFE_F00D;
            end else begin
               MemRead = 1'b1;
               size    = 2'b10;
               address = 32'h3C;
            end
         end
         @(posedge clk);
         #1;
         idle_inputs();
         chk("ready_sweep", 32'(ready), (i == DEPTH) ? 32'd1 : 32'd0);
         chk("valid_sweep", 32'(readValid), 32'd0);
         chk("fault_sweep", 32'(fault), 32'd0);
      end
      for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      exp_rd   = 32'd0;
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_valid", 32'(readValid), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      chk("rst_rdata", readData, 32'd0);

      sweep(1'b0);
      ld_expect("LW3C_clear", 2'b10, 1'b0, 32'h3C, 32'h0000_0000);
      ld_expect("LW00_ignored", 2'b10, 1'b0, 32'h00, 32'h0000_0000);

      // Sizes and extension
      req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF_7F01);
      ld_expect("LB10", 2'b00, 1'b0, 32'h10, 32'h0000_0001);
      ld_expect("LB11", 2'b00, 1'b0, 32'h11, 32'h0000_007F);
      ld_expect("LB12", 2'b00, 1'b0, 32'h12, 32'hFFFF_FFFF);
      ld_expect("LBU12", 2'b00, 1'b1, 32'h12, 32'h0000_00FF);
      ld_expect("LH12", 2'b01, 1'b0, 32'h12, 32'hFFFF_80FF);
      ld_expect("LHU12", 2'b01, 1'b1, 32'h12, 32'h0000_80FF);

      // Partial stores
      req(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
      req(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0000_00AA);
      req(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_BEEF);
      ld_expect("LW20_partial", 2'b10, 1'b0, 32'h20, 32'hBEEF_AA44);

      // Faults leave memory and readData alone
      req(1'b1, 1'b0, 2'b10, 1'b0, 32'h22, 32'd0);
      chk("fault_LW22", 32'(fault), 32'd1);
      req(1'b0, 1'b1, 2'b01, 1'b0, 32'h01, 32'h0000_5555);
      chk("fault_SH01", 32'(fault), 32'd1);
      req(1'b0, 1'b1, 2'b11, 1'b0, 32'h00, 32'hFFFF_FFFF);
      chk("fault_sz11", 32'(fault), 32'd1);
      req(1'b0, 1'b1, 2'b10, 1'b0, 32'h8000_0020, 32'hDEAD_BEEF);
      chk("fault_bit31", 32'(fault), 32'd1);
      req(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0BAD_0BAD);
      chk("fault_rdwr", 32'(fault), 32'd1);
      chk("fault_hold_rdata", readData, 32'hBEEF_AA44);
      ld_expect("LW00_after_fault", 2'b10, 1'b0, 32'h00, 32'h0000_0000);
      ld_expect("LW20_after_fault", 2'b10, 1'b0, 32'h20, 32'hBEEF_AA44);

      // Back-to-back store then load
      req(1'b0, 1'b1, 2'b10, 1'b0, 32'h08, 32'h1234_5678);
      ld_expect("LW08_b2b", 2'b10, 1'b0, 32'h08, 32'h1234_5678);
      req(1'b0, 1'b0, 2'b10, 1'b0, 32'h08, 32'd0);
      chk("b2b_valid_drop", 32'(readValid), 32'd0);

      // Randomized traffic
      for (int t = 0; t < 400; t++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         logic        rd;
         logic        wr;
         int          kind;
         kind = int'($urandom_range(0, 19));
         sz   = 2'($urandom_range(0, 2));
         if (kind == 0) sz = 2'b11;
         a = 32'($urandom_range(0, NBYTES - 1));
         if (kind == 1) a = a | (32'h1 << $urandom_range(AB + 2, 31));
         if (kind < 12 && kind != 2) begin
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
         end
         rd = ($urandom_range(0, 1) == 1);
         wr = !rd;
         if (kind == 3) wr = 1'b1;
         if (kind == 4) begin
            rd = 1'b0;
            wr = 1'b0;
         end
         req(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom);
      end

      // Reset in the middle of the sweep
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_rd = 32'd0;
      chk("rst2_rdata", readData, 32'd0);
      chk("rst2_ready", 32'(ready), 32'd0);
      sweep(1'b1);
      ld_expect("LW00_after_midrst", 2'b10, 1'b0, 32'h00, 32'h0000_0000);
      ld_expect("LW08_after_midrst", 2'b10, 1'b0, 32'h08, 32'h0000_0000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised byte-addressable data memory for the single-cycle/multicycle processor datapath. It generalises the word-only data memory: it adds load/store sizes (byte, half, word) with sign or zero extension, alignment and range checking with a fault flag, and a registered read with a valid strobe. It also adds a post-reset clear sweep with a ready handshake. It sits between the ALU result/register-file read port and the writeback mux.

## Interface

Parameters:
- `ADDR_BITS`, default 8: log2 of word depth; depth = 2**ADDR_BITS 32-bit words.
- `INIT_CLEAR`, default 1: 1 = zero every word after reset before accepting requests; 0 = skip the sweep.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `MemRead`  in  1  load request.
- `MemWrite`  in  1  store request.
- `size`  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- `unsignedLoad`  in  1  1 = zero-extend byte/half loads; 0 = sign-extend.
- `address`  in  32  byte address (ALU result).
- `writeData`  in  32  store data; byte/half taken from low bits.
- `ready`  out  1  block accepts a request this cycle.
- `readData`  out  32  load result, registered.
- `readValid`  out  1  one-cycle strobe: `readData` holds a new load result.
- `fault`  out  1  one-cycle strobe: the last accepted request was rejected.

## Operation

- The word index is `address[ADDR_BITS+1:2]`. The byte lane is `address[1:0]`. Lanes are little-endian: lane 0 is bits 7:0.
- A request is accepted on a rising edge when `ready`=1 and (`MemRead` | `MemWrite`)=1.
- Fault conditions are checked on the accepted request. On a fault, memory is unchanged, `readValid` stays 0, and `fault`=1 next cycle. The conditions are:
  - `MemRead`=`MemWrite`=1.
  - `size`=11.
  - Half access with `address[0]`=1.
  - Word access with `address[1:0]`≠0.
  - Any of `address[31:ADDR_BITS+2]` nonzero.
- Store: only the addressed lanes are written.
  - Byte: lane n ← `writeData[7:0]`.
  - Half: lanes {a1,a1+1} ← `writeData[15:0]`.
  - Word: all lanes ← `writeData`.
  - Other lanes retain their value.
- Load: the addressed byte or half is right-justified and extended per `unsignedLoad`. A word load returns the word unchanged and ignores `unsignedLoad`.
- `readData` holds its last value until the next successful load.
- FSM:
  - RESET: while `rst_n`=0.
  - CLEAR: counter 0..depth-1, one word zeroed per cycle, `ready`=0. Entered after reset when `INIT_CLEAR`=1.
  - IDLE: `ready`=1, services requests.
  - CLEAR→IDLE after writing word depth-1. With `INIT_CLEAR`=0, RESET→IDLE directly.
  - `rst_n` low in any state, including mid-CLEAR, returns to RESET; the sweep restarts from word 0.
- Requests presented while `ready`=0 are ignored, not queued.

## Timing

- Reset values (first edge with `rst_n`=0): `ready`=0, `readValid`=0, `fault`=0, `readData`=0, clear counter=0.
- After `rst_n` rises: `ready` goes 1 after 2**ADDR_BITS cycles (`INIT_CLEAR`=1), or 1 cycle later (`INIT_CLEAR`=0).
- Load latency: request accepted at edge N; `readData`/`readValid` valid after edge N, i.e. during cycle N+1. `readValid` deasserts at edge N+1 unless another load is accepted at that edge.
- Store is committed at the accepting edge. A load of the same address accepted at the next edge returns the new data; there is no stale read.
- Back-to-back requests every cycle are sustained in IDLE.
- `fault` has the same 1-cycle latency as `readValid`. The two are never both 1.

## Test plan

- Reset/clear, `ADDR_BITS`=4, `INIT_CLEAR`=1: hold `rst_n`=0 for 2 cycles, then release. Required: `ready`=0 for 16 cycles, then 1. A word load from 0x3C returns 0x00000000.
- Store/load sizes:
  - SW 0x80FF7F01 @0x10.
  - LB @0x10 → 0x00000001.
  - LB @0x11 → 0xFFFFFF7F? No: 0x0000007F (0x7F is positive).
  - LB @0x12 → 0xFFFFFFFF.
  - LBU @0x12 → 0x000000FF.
  - LH @0x12 → 0xFFFF80FF.
  - LHU @0x12 → 0x000080FF.
- Partial store: SW 0x11223344 @0x20, then SB 0xAA @0x21, then SH 0xBEEF @0x22. LW @0x20 → 0xBEEFAA44.
- Faults:
  - LW @0x22, SH @0x01, `size`=11, and an address with bit 31 set each give `fault`=1 for one cycle and `readValid`=0.
  - Memory at 0x00/0x20 is unchanged afterward.
  - `MemRead`=`MemWrite`=1 gives a fault and no write.
- Back-to-back: SW 0x12345678 @0x8 at edge N, LW @0x8 at edge N+1. Required: `readData`=0x12345678 with `readValid`=1 in cycle N+2, and `readValid`=0 in cycle N+3.
- Reset mid-clear: assert `rst_n`=0 at clear count 7 for 1 cycle. Required: the sweep restarts, `ready` rises a full depth later, and a request presented while `ready`=0 has no effect.
